// File: rtl/hlcp_pkg.sv
// rtl/hlcp_pkg.sv - shared types and constants for the HLCP ratio controller
package hlcp_pkg;

  localparam int HLCP_RATIO_W        = 6;
  localparam int HLCP_MAX_DIV_PERIOD = 1024;

  localparam logic [HLCP_RATIO_W-1:0] HLCP_RESET_RATIO = 6'd9;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    LOAD,
    SETTLE,
    ACK
  } hlcp_state_e;

  function automatic int hlcp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hlcp_ctrl_timer.sv
// rtl/hlcp_ctrl_timer.sv - loadable down-counter with zero flag
module hlcp_ctrl_timer #(
  parameter int W = 11
) (
  input  logic         sys_clk,
  input  logic         sys_resetb,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/hlcp_ratio_ctrl.sv
// rtl/hlcp_ratio_ctrl.sv - run-time ck_ratio change sequencer and clk_r strobe counter
import hlcp_pkg::*;

module hlcp_ratio_ctrl #(
  parameter logic [HLCP_RATIO_W-1:0] RESET_RATIO = HLCP_RESET_RATIO,
  parameter int                      DRAIN_TO    = 1024,
  parameter int                      SETTLE_CYC  = 2048,
  parameter bit                      ALLOW_DIV1  = 1'b0,
  parameter int                      CNT_W       = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_resetb,
  input  logic                    sw_en,
  input  logic                    cfg_req,
  input  logic [HLCP_RATIO_W-1:0] cfg_ratio,
  output logic                    cfg_ack,
  output logic                    cfg_err,
  input  logic                    core_busy,
  input  logic                    clk_r,
  output logic [HLCP_RATIO_W-1:0] ck_ratio,
  output logic                    core_en,
  output logic                    ctrl_busy,
  output logic [CNT_W-1:0]        tick_cnt
);

  localparam int TIMER_W = $clog2(hlcp_max(DRAIN_TO, SETTLE_CYC));

  hlcp_state_e state_q, state_d;

  logic               err_q;
  logic               err_set;
  logic               err_val;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic               tmr_zero;

  logic                    core_en_d;
  logic                    ctrl_busy_d;
  logic                    cfg_ack_d;
  logic                    cfg_err_d;
  logic [HLCP_RATIO_W-1:0] ck_ratio_d;
  logic [CNT_W-1:0]        tick_cnt_d;

  hlcp_ctrl_timer #(
    .W (TIMER_W)
  ) u_timer (
    .sys_clk    (sys_clk),
    .sys_resetb (sys_resetb),
    .load       (tmr_load),
    .load_val   (tmr_load_val),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      core_en   <= 1'b0;
      ctrl_busy <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      ck_ratio  <= RESET_RATIO;
      tick_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      if (err_set) begin
        err_q <= err_val;
      end
      core_en   <= core_en_d;
      ctrl_busy <= ctrl_busy_d;
      cfg_ack   <= cfg_ack_d;
      cfg_err   <= cfg_err_d;
      ck_ratio  <= ck_ratio_d;
      tick_cnt  <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_set      = 1'b0;
    err_val      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_req) begin
          if ((cfg_ratio == '0) && !ALLOW_DIV1) begin
            state_d = ACK;
            err_set = 1'b1;
            err_val = 1'b1;
          end else if (cfg_ratio == ck_ratio) begin
            state_d = ACK;
            err_set = 1'b1;
          end else begin
            state_d      = DRAIN;
            tmr_load     = 1'b1;
            tmr_load_val = TIMER_W'(DRAIN_TO - 1);
          end
        end
      end
      DRAIN: begin
        // A busy core on the zero-count edge aborts rather than loads.
        if (!core_busy) begin
          state_d = LOAD;
        end else if (tmr_zero) begin
          state_d = ACK;
          err_set = 1'b1;
          err_val = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      LOAD: begin
        state_d      = SETTLE;
        tmr_load     = 1'b1;
        tmr_load_val = TIMER_W'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = ACK;
          err_set = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ACK: begin
        if (!cfg_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values derive from the current state, so every output lags it by one edge.
  always_comb begin
    core_en_d   = ((state_q == IDLE) || (state_q == ACK)) ? sw_en : 1'b0;
    ctrl_busy_d = (state_q == DRAIN) || (state_q == LOAD) || (state_q == SETTLE);
    cfg_ack_d   = (state_q == ACK) && cfg_req;
    cfg_err_d   = cfg_ack_d && err_q;
    ck_ratio_d  = (state_q == LOAD) ? cfg_ratio : ck_ratio;
    if (state_q == LOAD) begin
      tick_cnt_d = '0;
    end else if (clk_r && !(&tick_cnt)) begin
      tick_cnt_d = tick_cnt + 1'b1;
    end else begin
      tick_cnt_d = tick_cnt;
    end
  end

endmodule
